// File: rtl/pipeline_hazard_ctl.sv
// pipeline_hazard_ctl: stall/flush/redirect/forwarding sequencer for a 5-stage RV32 pipeline.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_rs*/i_rd*/i_reg_wr_* hazard operands;
// i_result_src_e, i_pc_src_e, i_ecall_m, i_mret_m, i_mem_req_m, i_dmem_ready events;
// o_*_clk_en stage enables, o_*_flush bubbles, o_pc_sel redirect, o_fwd_*_e forwarding,
// o_stall_cnt saturating PC-stall cycles, o_mem_timeout sticky wait-state timeout.
module pipeline_hazard_ctl #(
  parameter logic [1:0] LOAD_SRC    = 2'b01,
  parameter int         STALL_CNT_W = 16,
  parameter int         MEM_TIMEOUT = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [4:0]             i_rs1_d,
  input  logic [4:0]             i_rs2_d,
  input  logic [4:0]             i_rs1_e,
  input  logic [4:0]             i_rs2_e,
  input  logic [4:0]             i_rd_e,
  input  logic [4:0]             i_rd_m,
  input  logic [4:0]             i_rd_w,
  input  logic                   i_reg_wr_m,
  input  logic                   i_reg_wr_w,
  input  logic [1:0]             i_result_src_e,
  input  logic                   i_pc_src_e,
  input  logic                   i_ecall_m,
  input  logic                   i_mret_m,
  input  logic                   i_mem_req_m,
  input  logic                   i_dmem_ready,
  output logic                   o_pc_clk_en,
  output logic                   o_if_id_clk_en,
  output logic                   o_id_ex_clk_en,
  output logic                   o_ex_mem_clk_en,
  output logic                   o_if_id_flush,
  output logic                   o_id_ex_flush,
  output logic                   o_ex_mem_flush,
  output logic                   o_mem_wb_flush,
  output logic [1:0]             o_pc_sel,
  output logic [1:0]             o_fwd_a_e,
  output logic [1:0]             o_fwd_b_e,
  output logic [STALL_CNT_W-1:0] o_stall_cnt,
  output logic                   o_mem_timeout
);
  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [1:0] {RUN, MEM_WAIT, TRAP, MRET} state_t;
  state_t          r_state, w_next;
  logic [WC_W-1:0] r_wait_cnt;
  logic            w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en;
  logic            w_if_id_fl, w_id_ex_fl, w_ex_mem_fl, w_mem_wb_fl;
  logic [1:0]      w_pc_sel, w_fwd_a, w_fwd_b;
  logic            w_mem_stall, w_load_use, w_at_limit, w_release, w_hit_timeout;
  assign w_fwd_a = (i_reg_wr_m && i_rd_m != 5'd0 && i_rd_m == i_rs1_e) ? 2'b10 :
                   (i_reg_wr_w && i_rd_w != 5'd0 && i_rd_w == i_rs1_e) ? 2'b01 : 2'b00;
  assign w_fwd_b = (i_reg_wr_m && i_rd_m != 5'd0 && i_rd_m == i_rs2_e) ? 2'b10 :
                   (i_reg_wr_w && i_rd_w != 5'd0 && i_rd_w == i_rs2_e) ? 2'b01 : 2'b00;
  assign w_mem_stall   = i_mem_req_m && !i_dmem_ready;
  assign w_load_use    = i_result_src_e == LOAD_SRC && i_rd_e != 5'd0 &&
                         (i_rd_e == i_rs1_d || i_rd_e == i_rs2_d);
  assign w_at_limit    = r_wait_cnt == WC_W'(MEM_TIMEOUT);
  // The timeout path releases exactly like a ready response so the pipeline cannot deadlock.
  assign w_release     = r_state == MEM_WAIT && (i_dmem_ready || w_at_limit);
  assign w_hit_timeout = r_state == MEM_WAIT && !i_dmem_ready && w_at_limit;
  always_comb begin
    w_pc_en     = 1'b1;
    w_if_id_en  = 1'b1;
    w_id_ex_en  = 1'b1;
    w_ex_mem_en = 1'b1;
    w_if_id_fl  = 1'b0;
    w_id_ex_fl  = 1'b0;
    w_ex_mem_fl = 1'b0;
    w_mem_wb_fl = 1'b0;
    w_pc_sel    = 2'b00;
    w_next      = r_state;
    case (r_state)
      RUN: begin
        if (w_mem_stall) begin
          {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en} = 4'b0000;
          w_mem_wb_fl = 1'b1;
          w_next      = MEM_WAIT;
        end else if (i_ecall_m || i_mret_m) begin
          {w_if_id_fl, w_id_ex_fl, w_ex_mem_fl} = 3'b111;
          w_pc_en = 1'b0;
          w_next  = i_ecall_m ? TRAP : MRET;
        end else if (i_pc_src_e) begin
          {w_if_id_fl, w_id_ex_fl} = 2'b11;
        end else if (w_load_use) begin
          {w_pc_en, w_if_id_en} = 2'b00;
          w_id_ex_fl = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (w_release) begin
          w_next = RUN;
        end else begin
          {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en} = 4'b0000;
          w_mem_wb_fl = 1'b1;
        end
      end
      TRAP, MRET: begin
        w_pc_sel = r_state == TRAP ? 2'b01 : 2'b10;
        {w_if_id_fl, w_id_ex_fl} = 2'b11;
        w_next = RUN;
      end
      default: w_next = RUN;
    endcase
  end
  // Reset forces a frozen, fully flushed pipeline independent of the clock.
  assign o_pc_clk_en     = i_rst_n & w_pc_en;
  assign o_if_id_clk_en  = i_rst_n & w_if_id_en;
  assign o_id_ex_clk_en  = i_rst_n & w_id_ex_en;
  assign o_ex_mem_clk_en = i_rst_n & w_ex_mem_en;
  assign o_if_id_flush   = !i_rst_n | w_if_id_fl;
  assign o_id_ex_flush   = !i_rst_n | w_id_ex_fl;
  assign o_ex_mem_flush  = !i_rst_n | w_ex_mem_fl;
  assign o_mem_wb_flush  = !i_rst_n | w_mem_wb_fl;
  assign o_pc_sel        = i_rst_n ? w_pc_sel : 2'b00;
  assign o_fwd_a_e       = i_rst_n ? w_fwd_a : 2'b00;
  assign o_fwd_b_e       = i_rst_n ? w_fwd_b : 2'b00;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= RUN;
      r_wait_cnt    <= '0;
      o_stall_cnt   <= '0;
      o_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_wait_cnt    <= (r_state == RUN && w_mem_stall) ? WC_W'(1) :
                       (r_state == MEM_WAIT && !w_release) ? r_wait_cnt + WC_W'(1) : '0;
      o_stall_cnt   <= (!w_pc_en && o_stall_cnt != '1) ? o_stall_cnt + 1'b1 : o_stall_cnt;
      o_mem_timeout <= o_mem_timeout | w_hit_timeout;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctl.sv
// tb_pipeline_hazard_ctl: directed self-checking bench for pipeline_hazard_ctl.
module tb_pipeline_hazard_ctl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       reg_wr_m, reg_wr_w, pc_src_e, ecall_m, mret_m, mem_req_m, dmem_ready;
  logic [1:0] result_src_e;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl;
  logic [1:0] pc_sel, fwd_a, fwd_b;
  logic [3:0] stall_cnt;
  logic       mem_timeout;
  logic [9:0] ctl;
  int         checks = 0;
  int         errors = 0;
  localparam logic [9:0] C_NORM = 10'b1111_0000_00;
  localparam logic [9:0] C_RST  = 10'b0000_1111_00;
  localparam logic [9:0] C_LU   = 10'b0011_0100_00;
  localparam logic [9:0] C_FRZ  = 10'b0000_0001_00;
  localparam logic [9:0] C_ECL  = 10'b0111_1110_00;
  localparam logic [9:0] C_TRP  = 10'b1111_1100_01;
  localparam logic [9:0] C_MRT  = 10'b1111_1100_10;
  localparam logic [9:0] C_BR   = 10'b1111_1100_00;
  assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl, pc_sel};
  always #5 clk = ~clk;
  pipeline_hazard_ctl #(.LOAD_SRC(2'b01), .STALL_CNT_W(4), .MEM_TIMEOUT(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rs1_d(rs1_d), .i_rs2_d(rs2_d), .i_rs1_e(rs1_e), .i_rs2_e(rs2_e),
    .i_rd_e(rd_e), .i_rd_m(rd_m), .i_rd_w(rd_w),
    .i_reg_wr_m(reg_wr_m), .i_reg_wr_w(reg_wr_w), .i_result_src_e(result_src_e),
    .i_pc_src_e(pc_src_e), .i_ecall_m(ecall_m), .i_mret_m(mret_m),
    .i_mem_req_m(mem_req_m), .i_dmem_ready(dmem_ready),
    .o_pc_clk_en(pc_en), .o_if_id_clk_en(if_id_en), .o_id_ex_clk_en(id_ex_en),
    .o_ex_mem_clk_en(ex_mem_en), .o_if_id_flush(if_id_fl), .o_id_ex_flush(id_ex_fl),
    .o_ex_mem_flush(ex_mem_fl), .o_mem_wb_flush(mem_wb_fl), .o_pc_sel(pc_sel),
    .o_fwd_a_e(fwd_a), .o_fwd_b_e(fwd_b), .o_stall_cnt(stall_cnt), .o_mem_timeout(mem_timeout)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle();
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
    {reg_wr_m, reg_wr_w, pc_src_e, ecall_m, mret_m, mem_req_m} = '0;
    result_src_e = 2'b00;
    dmem_ready   = 1'b1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    idle();
    rs1_e = 5'd7; rd_m = 5'd7; reg_wr_m = 1'b1;
    #7;
    check("rst_ctl", ctl, C_RST);
    check("rst_fwd", fwd_a, 2'b00);
    check("rst_stall", stall_cnt, 0);
    check("rst_tmo", mem_timeout, 0);
    #5 rst_n = 1'b1;
    tick();
    rd_w = 5'd7; reg_wr_w = 1'b1; rs2_e = 5'd7; #1;
    check("fwd_a_mem", fwd_a, 2'b10);
    check("fwd_b_mem", fwd_b, 2'b10);
    check("fwd_ctl", ctl, C_NORM);
    reg_wr_m = 1'b0; #1;
    check("fwd_a_wb", fwd_a, 2'b01);
    rs2_e = 5'd3; #1;
    check("fwd_b_none", fwd_b, 2'b00);
    idle(); reg_wr_m = 1'b1; reg_wr_w = 1'b1; #1;
    check("fwd_a_x0", fwd_a, 2'b00);
    idle(); result_src_e = 2'b01; rd_e = 5'd5; rs1_d = 5'd5; #1;
    check("lu_ctl", ctl, C_LU);
    tick();
    idle(); #1;
    check("lu_after", ctl, C_NORM);
    check("lu_stall", stall_cnt, 1);
    result_src_e = 2'b01; rd_e = 5'd0; rs2_d = 5'd0; #1;
    check("lu_x0", ctl, C_NORM);
    rd_e = 5'd9; rs2_d = 5'd9; pc_src_e = 1'b1; #1;
    check("br_lu", ctl, C_BR);
    idle(); mem_req_m = 1'b1; dmem_ready = 1'b0; #1;
    check("mw_c1", ctl, C_FRZ);
    tick();
    pc_src_e = 1'b1; #1;
    check("mw_c2", ctl, C_FRZ);
    tick();
    pc_src_e = 1'b0; #1;
    check("mw_c3", ctl, C_FRZ);
    tick();
    dmem_ready = 1'b1; #1;
    check("mw_rel", ctl, C_NORM);
    tick();
    idle(); #1;
    check("mw_stall", stall_cnt, 4);
    check("mw_tmo", mem_timeout, 0);
    mem_req_m = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("to_frz%0d", i), ctl, C_FRZ);
      tick();
    end
    check("to_rel", ctl, C_NORM);
    check("to_pend", mem_timeout, 0);
    tick();
    idle(); #1;
    check("to_flag", mem_timeout, 1);
    check("to_stall", stall_cnt, 8);
    ecall_m = 1'b1; mret_m = 1'b1; #1;
    check("ecall_n", ctl, C_ECL);
    tick();
    idle(); #1;
    check("ecall_n1", ctl, C_TRP);
    tick();
    check("ecall_n2", ctl, C_NORM);
    mret_m = 1'b1; #1;
    check("mret_n", ctl, C_ECL);
    tick();
    idle(); #1;
    check("mret_n1", ctl, C_MRT);
    tick();
    check("mret_n2", ctl, C_NORM);
    check("trap_stall", stall_cnt, 10);
    check("to_sticky", mem_timeout, 1);
    result_src_e = 2'b01; rd_e = 5'd4; rs2_d = 5'd4;
    repeat (10) tick();
    check("sat_stall", stall_cnt, 15);
    idle(); mem_req_m = 1'b1; dmem_ready = 1'b0;
    tick();
    check("ar_frz", ctl, C_FRZ);
    #2 rst_n = 1'b0;
    #1;
    check("ar_ctl", ctl, C_RST);
    check("ar_stall", stall_cnt, 0);
    check("ar_tmo", mem_timeout, 0);
    idle();
    #1 rst_n = 1'b1;
    tick();
    check("ar_run", ctl, C_NORM);
    mem_req_m = 1'b1; dmem_ready = 1'b0; #1;
    check("ar_state", ctl, C_FRZ);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
